// File: rtl/rocc_cmd_issuer.sv
`timescale 1ns/1ps
// Host-side initiator for rocc_accel: buffers commands in a FIFO and issues them
// one at a time over the valid/ready busy-handshake, reporting completions and hangs.
module rocc_cmd_issuer #(
  parameter int unsigned INST_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned ACK_TIMEOUT  = 64,
  parameter int unsigned DONE_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [INST_WIDTH-6:0] cmd_inst,
  input  logic [DATA_WIDTH-1:0] cmd_rs1,
  input  logic [DATA_WIDTH-1:0] cmd_rs2,
  output logic [INST_WIDTH-6:0] inst,
  output logic [DATA_WIDTH-1:0] rs1,
  output logic [DATA_WIDTH-1:0] rs2,
  output logic                  valid,
  input  logic                  ready,
  output logic                  busy,
  output logic                  done_pulse,
  output logic [4:0]            done_rd,
  output logic [15:0]           done_count,
  output logic                  timeout_err
);

  localparam int unsigned CW   = INST_WIDTH - 5;
  localparam int unsigned EW   = CW + 2 * DATA_WIDTH;
  localparam int unsigned PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned NW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TMAX = (ACK_TIMEOUT > DONE_TIMEOUT) ? ACK_TIMEOUT : DONE_TIMEOUT;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam bit          ACK_EN  = (ACK_TIMEOUT != 0);
  localparam bit          DONE_EN = (DONE_TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_EXEC  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [EW-1:0]         mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]         count_q, count_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [CW-1:0]         inst_q, inst_d;
  logic [DATA_WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic                  valid_q, valid_d;
  logic                  done_pulse_q, done_pulse_d;
  logic [4:0]            done_rd_q, done_rd_d;
  logic [15:0]           done_count_q, done_count_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  busy_q, busy_d;
  logic                  push, pop;
  logic [EW-1:0]         head;

  assign push = cmd_valid && cmd_ready_q;
  assign head = mem_q[rd_ptr_q];

  // FIFO storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_inst, cmd_rs1, cmd_rs2};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      timer_q       <= '0;
      inst_q        <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      valid_q       <= 1'b0;
      done_pulse_q  <= 1'b0;
      done_rd_q     <= '0;
      done_count_q  <= '0;
      timeout_err_q <= 1'b0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      timer_q       <= timer_d;
      inst_q        <= inst_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      valid_q       <= valid_d;
      done_pulse_q  <= done_pulse_d;
      done_rd_q     <= done_rd_d;
      done_count_q  <= done_count_d;
      timeout_err_q <= timeout_err_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    inst_d        = inst_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    valid_d       = valid_q;
    done_pulse_d  = 1'b0;
    done_rd_d     = done_rd_q;
    done_count_d  = done_count_q;
    timeout_err_d = timeout_err_q;
    pop           = 1'b0;

    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        // Only launch when the accelerator reports idle.
        if ((count_q != '0) && ready) begin
          {inst_d, rs1_d, rs2_d} = head;
          pop     = 1'b1;
          valid_d = 1'b1;
          timer_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!ready) begin
          valid_d = 1'b0;
          timer_d = '0;
          state_d = S_EXEC;
        end else if (ACK_EN && (timer_q == TW'(ACK_TIMEOUT - 1))) begin
          valid_d       = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_EXEC: begin
        valid_d = 1'b0;
        if (ready) begin
          done_pulse_d = 1'b1;
          done_rd_d    = inst_q[6:2];
          done_count_d = done_count_q + 16'd1;
          state_d      = S_IDLE;
        end else if (DONE_EN && (timer_q == TW'(DONE_TIMEOUT - 1))) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    wr_ptr_d    = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d    = pop  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    count_d     = count_q + NW'(push) - NW'(pop);
    cmd_ready_d = (count_d != NW'(FIFO_DEPTH));
    busy_d      = (state_d != S_IDLE) || (count_d != '0);
  end

  assign cmd_ready   = cmd_ready_q;
  assign inst        = inst_q;
  assign rs1         = rs1_q;
  assign rs2         = rs2_q;
  assign valid       = valid_q;
  assign busy        = busy_q;
  assign done_pulse  = done_pulse_q;
  assign done_rd     = done_rd_q;
  assign done_count  = done_count_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_rocc_cmd_issuer.sv
`timescale 1ns/1ps
// Scoreboard bench for rocc_cmd_issuer: a negedge accelerator model plus an
// independent monitor that checks issue order, handshake length and completions.
module tb_rocc_cmd_issuer;

  localparam int unsigned IW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = IW - 5;
  localparam int unsigned ACK_TO  = 64;
  localparam int unsigned DONE_TO = 1024;

  // mode 0: normal completion, 1: never acknowledged, 2: never completes
  typedef struct {
    logic [CW-1:0] inst;
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;
    int            mode;
    int            ack_d;
    int            exe_d;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [CW-1:0] cmd_inst = '0;
  logic [DW-1:0] cmd_rs1 = '0;
  logic [DW-1:0] cmd_rs2 = '0;
  logic [CW-1:0] inst;
  logic [DW-1:0] rs1, rs2;
  logic          valid;
  logic          ready = 1'b1;
  logic          busy, done_pulse, timeout_err;
  logic [4:0]    done_rd;
  logic [15:0]   done_count;

  rocc_cmd_issuer #(
    .INST_WIDTH(IW), .DATA_WIDTH(DW), .FIFO_DEPTH(4),
    .ACK_TIMEOUT(ACK_TO), .DONE_TIMEOUT(DONE_TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_inst(cmd_inst), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .inst(inst), .rs1(rs1), .rs2(rs2), .valid(valid), .ready(ready),
    .busy(busy), .done_pulse(done_pulse), .done_rd(done_rd),
    .done_count(done_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  cmd_t        issue_q[$];
  cmd_t        acc_q[$];
  logic [4:0]  done_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_cnt = '0;
  bit          exp_to = 1'b0;
  bit          hold_busy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Accelerator model: ready drops ack_d cycles after valid is seen, rises exe_d later.
  int   acc_st = 0;
  int   acc_cnt = 0;
  int   acc_tgt = 0;
  cmd_t acc_cur;
  always @(negedge clk) begin
    if (rst) begin
      acc_st  = 0;
      acc_cnt = 0;
      ready   = 1'b1;
    end else if (acc_st == 3) begin
      if (!valid) acc_st = 0;
    end else if (acc_st == 2) begin
      if (acc_cnt >= acc_tgt) begin
        ready  = 1'b1;
        acc_st = 0;
      end else acc_cnt++;
    end else begin
      if (acc_st == 0) begin
        ready = hold_busy ? 1'b0 : 1'b1;
        if (valid) begin
          if (acc_q.size() != 0) acc_cur = acc_q.pop_front();
          else acc_cur.mode = 1;
          acc_tgt = (acc_cur.mode == 2) ? int'(DONE_TO) + 8 : acc_cur.exe_d;
          acc_cnt = 0;
          acc_st  = (acc_cur.mode == 1) ? 3 : 1;
        end
      end
      if (acc_st == 1) begin
        if (acc_cnt == acc_cur.ack_d) begin
          ready   = 1'b0;
          acc_cnt = 0;
          acc_st  = 2;
        end else acc_cnt++;
      end
    end
  end

  // Monitor: pops expected issues/completions as the DUT presents them.
  bit   pv = 1'b0;
  bit   pdp = 1'b0;
  int   vh = 0;
  cmd_t cur;
  logic [4:0] exp_rd;
  always @(negedge clk) begin
    if (rst) begin
      pv  = 1'b0;
      pdp = 1'b0;
      vh  = 0;
    end else begin
      if (valid && !pv) begin
        if (issue_q.size() == 0) fail("unexpected_issue");
        else begin
          cur = issue_q.pop_front();
          chk("issue_inst", 64'(inst), 64'(cur.inst));
          chk("issue_rs1", rs1, cur.rs1);
          chk("issue_rs2", rs2, cur.rs2);
        end
        vh = 1;
      end else if (valid && pv) begin
        vh++;
        chk("hold_inst", 64'(inst), 64'(cur.inst));
        chk("hold_rs2", rs2, cur.rs2);
      end else if (!valid && pv) begin
        chk("valid_len", 64'(vh), (cur.mode == 1) ? 64'(ACK_TO) : 64'(cur.ack_d + 1));
        if (cur.mode == 1) exp_to = 1'b1;
      end
      if (done_pulse) begin
        chk("done_single", 64'(pdp), 64'd0);
        if (done_q.size() == 0) fail("unexpected_done");
        else begin
          exp_rd    = done_q.pop_front();
          model_cnt = model_cnt + 16'd1;
          chk("done_rd", 64'(done_rd), 64'(exp_rd));
          chk("done_count", 64'(done_count), 64'(model_cnt));
        end
      end
      pv  = valid;
      pdp = done_pulse;
    end
  end

  function automatic cmd_t mk(input logic [4:0] rd, input int mode, input int ack_d, input int exe_d);
    cmd_t c;
    c.inst      = CW'($urandom());
    c.inst[6:2] = rd;
    c.rs1       = {$urandom(), $urandom()};
    c.rs2       = {$urandom(), $urandom()};
    c.mode      = mode;
    c.ack_d     = ack_d;
    c.exe_d     = exe_d;
    return c;
  endfunction

  task automatic push(input cmd_t c);
    int t = 0;
    cmd_valid = 1'b1;
    cmd_inst  = c.inst;
    cmd_rs1   = c.rs1;
    cmd_rs2   = c.rs2;
    while (!cmd_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      fail("push_stall");
      cmd_valid = 1'b0;
      return;
    end
    issue_q.push_back(c);
    acc_q.push_back(c);
    if (c.mode == 0) done_q.push_back(c.inst[6:2]);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (!(!busy && issue_q.size() == 0 && done_q.size() == 0 && acc_st == 0 && ready) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 4000) fail(name);
    else begin
      chk({name, "_timeout_err"}, 64'(timeout_err), 64'(exp_to));
      chk({name, "_done_count"}, 64'(done_count), 64'(model_cnt));
      chk({name, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    issue_q.delete();
    acc_q.delete();
    done_q.delete();
    model_cnt = '0;
    exp_to    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t c;
    int   t;
    int   n;

    // Reset values
    do_reset();
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_done_count", 64'(done_count), 64'd0);
    chk("rst_timeout", 64'(timeout_err), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);

    // Single command
    c = mk(5'd1, 0, 2, 10);
    c.inst = {7'h01, 5'd1, 5'd0, 1'b1, 1'b1, 1'b1, 5'd1, 2'b00};
    c.rs1  = 64'h40000000_40000000;
    c.rs2  = 64'h40000000_40000000;
    push(c);
    drain("t1");

    // Four queued behind a busy accelerator
    do_reset();
    hold_busy = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 4; i++) push(mk(5'(i), 0, 1, 2));
    chk("t2_full", 64'(cmd_ready), 64'd0);
    chk("t2_no_issue", 64'(valid), 64'd0);
    chk("t2_busy", 64'(busy), 64'd1);
    hold_busy = 1'b0;
    drain("t2");

    // Completion timeout
    do_reset();
    push(mk(5'd7, 2, 1, 0));
    t = 0;
    while (!valid && t < 100) begin @(negedge clk); t++; end
    while (valid && t < 200) begin @(negedge clk); t++; end
    n = 0;
    while (!timeout_err && n < 2000) begin @(negedge clk); n++; end
    chk("t4_exec_cycles", 64'(n), 64'(DONE_TO));
    chk("t4_idle", 64'(busy), 64'd0);
    exp_to = 1'b1;
    drain("t4");

    // Acknowledge timeout, next command still issues
    do_reset();
    push(mk(5'd9, 1, 0, 0));
    push(mk(5'd10, 0, 3, 4));
    drain("t3");

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      c = mk(5'($urandom()), ($urandom_range(7) == 0) ? 1 : 0,
             int'($urandom_range(5)), int'($urandom_range(6)));
      push(c);
      repeat ($urandom_range(3)) @(negedge clk);
    end
    drain("rand");

    // Reset while executing with two entries queued
    do_reset();
    push(mk(5'd11, 0, 1, 30));
    push(mk(5'd12, 0, 1, 1));
    push(mk(5'd13, 0, 1, 1));
    t = 0;
    while (!(issue_q.size() == 2 && !valid && acc_st == 2) && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) fail("t5_reach_exec");
    rst = 1'b1;
    #1;
    chk("t5_valid", 64'(valid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_done_count", 64'(done_count), 64'd0);
    issue_q.delete();
    acc_q.delete();
    done_q.delete();
    model_cnt = '0;
    exp_to    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_cmd_ready", 64'(cmd_ready), 64'd1);
    push(mk(5'd14, 0, 0, 2));
    drain("t5");

    // done_count wrap
    @(negedge clk);
    force dut.done_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.done_count_q;
    model_cnt = 16'hFFFF;
    push(mk(5'd21, 0, 1, 1));
    push(mk(5'd22, 0, 0, 0));
    drain("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rocc_cmd_issuer.md
Name: rocc_cmd_issuer

Overview:
Host-side initiator for the rocc_accel command interface. It buffers CPU-side commands (instruction bits [31:5] plus rs1/rs2) in a small FIFO and drives them one at a time into rocc_accel using the valid/ready busy-handshake. It tracks acceptance and completion, reports completion events, and flags hung transactions. It sits between the core's command source and rocc_accel, replacing hand-driven stimulus.

Parameters:
INST_WIDTH, 32, full instruction width; the command path carries bits [INST_WIDTH-1:5].
DATA_WIDTH, 64, width of rs1/rs2 operands.
FIFO_DEPTH, 4, command FIFO entries; must be a power of 2, ≥2.
ACK_TIMEOUT, 64, maximum cycles valid may stay high without ready falling; 0 disables the check.
DONE_TIMEOUT, 1024, maximum cycles in EXEC without ready rising; 0 disables the check.

Ports:
clk  in  1  clock; all logic is rising-edge.
rst  in  1  asynchronous, active-high reset.
cmd_valid  in  1  upstream command present.
cmd_ready  out  1  FIFO can accept; equals !full.
cmd_inst  in  INST_WIDTH-5  instruction bits [31:5]: funct7, rs2, rs1, xd, xs1, xs2, rd, opcode[6:5].
cmd_rs1  in  DATA_WIDTH  operand 1.
cmd_rs2  in  DATA_WIDTH  operand 2.
inst  out  INST_WIDTH-5  to rocc_accel.inst.
rs1  out  DATA_WIDTH  to rocc_accel.rs1.
rs2  out  DATA_WIDTH  to rocc_accel.rs2.
valid  out  1  to rocc_accel.valid.
ready  in  1  from rocc_accel.ready; 1 = idle, 0 = busy.
busy  out  1  high if state != IDLE or the FIFO is non-empty.
done_pulse  out  1  one-cycle pulse on each completion.
done_rd  out  5  rd field (inst[11:7]) of the last completed command.
done_count  out  16  completed-command counter; wraps 0xFFFF→0.
timeout_err  out  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset (async assert): valid=0; inst/rs1/rs2=0; done_pulse=0; done_rd=0; done_count=0; timeout_err=0; FIFO emptied; state=IDLE; cmd_ready=1 after deassert. Reset mid-transaction abandons the command with no completion reported.
- FIFO: push on cmd_valid && cmd_ready. Pop only on the IDLE→ISSUE edge. Push and pop in the same cycle are allowed. There is no bypass: a pushed entry is visible to the FSM the cycle after the push. When full, cmd_ready=0 and cmd_valid is ignored.
- All outputs are registered; the FSM samples the ready input each edge.
- IDLE: if the FIFO is non-empty and ready==1, then at the next edge: load inst/rs1/rs2 from the FIFO head, pop, set valid=1, clear the timer, go to ISSUE. Otherwise stay, with valid=0.
- ISSUE: valid held high and operands held stable.
  - ready==0 sampled → next edge valid=0, clear timer, go to EXEC (command accepted).
  - Else, if ACK_TIMEOUT != 0 and the timer reaches ACK_TIMEOUT-1 → valid=0, timeout_err=1, go to IDLE; the command is dropped with no done_pulse.
- EXEC: valid=0; inst/rs1/rs2 retain their last values.
  - ready==1 sampled → next edge done_pulse=1, done_rd=inst[11:7], done_count+=1, go to IDLE.
  - DONE_TIMEOUT expiry behaves like ACK_TIMEOUT: timeout_err=1, go to IDLE.
- Back-to-back commands: the earliest next issue is the edge after done_pulse. Minimum spacing is done (IDLE) → ISSUE, one cycle.
- ready already low in IDLE: wait; never assert valid while ready==0.
- done_pulse is high for exactly one cycle per completion, never on a timeout.
- A timeout does not stall the FSM; subsequent commands continue issuing.

Test Plan:
1. Reset, push inst={7'h01,5'd1,5'd0,1,1,1,5'd1,2'b00}, rs1=rs2=64'h40000000_40000000; model drops ready 2 cycles after valid and raises it 10 cycles later → valid high until ready falls; done_pulse once; done_rd=1; done_count=1.
2. Push 4 commands (rd=1..4) back-to-back with the accelerator busy → cmd_ready=0 after the 4th; issues occur in FIFO order; done_rd sequence 1,2,3,4; done_count=4; busy falls after the last done.
3. ready held high forever after valid with ACK_TIMEOUT=64 → valid drops after 64 cycles, timeout_err=1, no done_pulse; the next queued command still issues.
4. ready held low forever after acceptance with DONE_TIMEOUT=1024 → timeout_err=1 at cycle 1024 of EXEC; state returns to IDLE.
5. Assert rst while in EXEC with 2 entries queued → valid=0 immediately; FIFO empty; done_count=0; cmd_ready=1 after release.
6. Preload done_count=0xFFFF via 65535 completions (or force) plus 1 more → done_count=0x0000; done_pulse still asserted for that completion.
